// File: rtl/ex_hazard_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_if
// Bundle between the pipeline datapath and the EX-stage hazard controller.
//   master : pipeline side; drives the hazard-detection inputs and consumes
//            the stall/flush/bubble controls and the perf/error status.
//   slave  : hazard controller side (ex_hazard_ctrl).
// Signals:
//   ifid_regRS1/2      source registers of the instruction in ID
//   idex_regRD         destination register of the instruction in EX
//   idex_memRead       EX instruction is a load
//   idex_md_valid      EX instruction is a MUL/DIV op
//   md_done            shared mul/div result valid (single-cycle pulse)
//   exmem_branch_taken branch/jump in MEM resolved taken
//   perf_clr           clear stall counter and sticky error flag
//   pc_write/ifid_write, idex_bubble, ifid_flush/idex_flush, ex_hold,
//   exmem_bubble, md_start, md_abort, md_err, stall_cycles : controls/status
// ----------------------------------------------------------------------------
interface ex_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ifid_regRS1;
    logic [4:0]       ifid_regRS2;
    logic [4:0]       idex_regRD;
    logic             idex_memRead;
    logic             idex_md_valid;
    logic             md_done;
    logic             exmem_branch_taken;
    logic             perf_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             ex_hold;
    logic             exmem_bubble;
    logic             md_start;
    logic             md_abort;
    logic             md_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ifid_regRS1, ifid_regRS2, idex_regRD, idex_memRead,
               idex_md_valid, md_done, exmem_branch_taken, perf_clr,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               ex_hold, exmem_bubble, md_start, md_abort, md_err, stall_cycles
    );

    modport slave (
        input  ifid_regRS1, ifid_regRS2, idex_regRD, idex_memRead,
               idex_md_valid, md_done, exmem_branch_taken, perf_clr,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               ex_hold, exmem_bubble, md_start, md_abort, md_err, stall_cycles
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
// EX-stage hazard controller: branch flush, load-use stall, and sequencing of
// the shared multi-cycle mul/div unit with a timeout abort.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   hz   : ex_hazard_if.slave bundle (hazard inputs, pipeline controls,
//          md_err sticky timeout flag, saturating stall_cycles counter)
// Parameters:
//   MD_TIMEOUT : max cycles spent waiting for md_done before aborting
//   CNT_W      : width of the stall-cycle counter
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_hazard_if.slave   hz
);
    localparam int TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             err_q, err_d;

    logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush;
    logic ex_hold, exmem_bubble, md_start, md_abort;
    logic load_use;

    // A load writing x0 never creates a real dependency.
    assign load_use = hz.idex_memRead && (hz.idex_regRD != 5'd0) &&
                      ((hz.idex_regRD == hz.ifid_regRS1) ||
                       (hz.idex_regRD == hz.ifid_regRS2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            to_q    <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        to_d         = to_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        ex_hold      = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;
        md_abort     = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.exmem_branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed;
                    // this also cancels a MUL/DIV sitting in EX.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hz.idex_md_valid) begin
                    md_start     = 1'b1;
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    to_d         = '0;
                    state_d      = MD_WAIT;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                // md_done has priority over the timeout in the same cycle.
                // Branches are ignored here: EX/MEM only carries bubbles.
                if (hz.md_done) begin
                    state_d = RUN;
                end else if (to_q == TO_W'(MD_TIMEOUT - 1)) begin
                    md_abort = 1'b1;
                    state_d  = RUN;
                end else begin
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    to_d         = to_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // Hold the whole pipeline quiet while reset is asserted.
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            ex_hold      = 1'b0;
            exmem_bubble = 1'b0;
            md_start     = 1'b0;
            md_abort     = 1'b0;
        end

        // perf_clr overrides both the increment and the error set.
        if (hz.perf_clr) begin
            stall_d = '0;
            err_d   = 1'b0;
        end else begin
            stall_d = (!pc_write && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
            err_d   = err_q | md_abort;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.ifid_write   = ifid_write;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.ex_hold      = ex_hold;
    assign hz.exmem_bubble = exmem_bubble;
    assign hz.md_start     = md_start;
    assign hz.md_abort     = md_abort;
    assign hz.md_err       = err_q;
    assign hz.stall_cycles = stall_q;
endmodule
